// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers (wptr_full, rptr_empty).
package fifo_pkg;

    localparam int DEF_ADDRSIZEL = 4;

    // Zero-extend narrower operands; the conversion is then correct for any width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side FIFO bus: writer request/overflow-clear, synchronised read pointer, RAM port and flags.
interface wptr_full_if import fifo_pkg::*; #(
    parameter int ADDRSIZEL = DEF_ADDRSIZEL
);
    logic                 winc;
    logic [ADDRSIZEL:0]   wq2_rptr;
    logic                 wovf_clr;
    logic                 wen;
    logic [ADDRSIZEL-1:0] waddr;
    logic [ADDRSIZEL:0]   wptr;
    logic                 wfull;
    logic                 walmost_full;
    logic [ADDRSIZEL:0]   wlevel;
    logic                 wovf;

    modport master (
        output winc, wq2_rptr, wovf_clr,
        input  wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );

    modport slave (
        input  winc, wq2_rptr, wovf_clr,
        output wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB), shared by both FIFO pointer controllers.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer/flag controller of the dual-clock FIFO: Gray write pointer, RAM write port,
// full/almost-full/level computed against the synchronised read pointer, and a sticky overflow flag.
module wptr_full import fifo_pkg::*; #(
    parameter int ADDRSIZEL    = DEF_ADDRSIZEL,
    parameter int AFULL_THRESH = 12
) (
    input  logic       wclk,
    input  logic       wrst_n,
    wptr_full_if.slave bus
);

    localparam int             PW      = ADDRSIZEL + 1;
    localparam logic [PW-1:0]  AFULL_L = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] wlevel_r;
    logic          wfull_r;
    logic          walmost_full_r;
    logic          wovf_r;

    logic          wen_s;
    logic          ovf_evt_s;
    logic [PW-1:0] wbinnext_s;
    logic [PW-1:0] wgraynext_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] lvl_next_s;
    logic [PW-1:0] full_ptr_s;

    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .gray (bus.wq2_rptr),
        .bin  (rbin_s)
    );

    // Next pointer, level and the "read pointer one lap behind" pattern that means full.
    always_comb begin
        wen_s       = bus.winc & ~wfull_r;
        ovf_evt_s   = bus.winc & wfull_r;
        wbinnext_s  = wbin_r + {{ADDRSIZEL{1'b0}}, wen_s};
        wgraynext_s = PW'(bin2gray(32'(wbinnext_s)));
        lvl_next_s  = wbinnext_s - rbin_s;
        full_ptr_s  = {~bus.wq2_rptr[ADDRSIZEL -: 2], bus.wq2_rptr[ADDRSIZEL-2:0]};
    end

    // Pointer and flag registers; a new overflow takes priority over a clear in the same cycle.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_r         <= '0;
            wptr_r         <= '0;
            wlevel_r       <= '0;
            wfull_r        <= 1'b0;
            walmost_full_r <= 1'b0;
            wovf_r         <= 1'b0;
        end else begin
            wbin_r         <= wbinnext_s;
            wptr_r         <= wgraynext_s;
            wlevel_r       <= lvl_next_s;
            wfull_r        <= (wgraynext_s == full_ptr_s);
            walmost_full_r <= (lvl_next_s >= AFULL_L);
            wovf_r         <= ovf_evt_s | (wovf_r & ~bus.wovf_clr);
        end
    end

    assign bus.wen          = wen_s;
    assign bus.waddr        = wbin_r[ADDRSIZEL-1:0];
    assign bus.wptr         = wptr_r;
    assign bus.wfull        = wfull_r;
    assign bus.walmost_full = walmost_full_r;
    assign bus.wlevel       = wlevel_r;
    assign bus.wovf         = wovf_r;

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: stimulus queues expected post-edge state, a monitor compares each cycle.
module tb_wptr_full;

    typedef struct {
        string      nm;
        logic [6:0] m;      // 0 wen,1 waddr,2 wptr,3 wfull,4 walmost_full,5 wlevel,6 wovf
        logic       wen;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       waf;
        logic [4:0] wlevel;
        logic       wovf;
        logic       hd;
    } exp_t;

    localparam logic [6:0] ALL   = 7'h7F;
    localparam logic [6:0] NOWEN = 7'h7E;

    logic wclk;
    logic wrst_n;
    int   checks;
    int   failures;
    int   wraps;
    exp_t sb[$];

    wptr_full_if #(.ADDRSIZEL(4)) bus ();

    wptr_full #(.ADDRSIZEL(4), .AFULL_THRESH(12)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] g(input int x);
        logic [4:0] b;
        b = 5'(x);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t mk(input string nm, input logic [6:0] m, input logic wen,
                                input logic [3:0] a, input logic [4:0] p, input logic f,
                                input logic af, input logic [4:0] l, input logic o,
                                input logic hd = 1'b0);
        exp_t e;
        e.nm = nm; e.m = m; e.wen = wen; e.waddr = a; e.wptr = p; e.wfull = f;
        e.waf = af; e.wlevel = l; e.wovf = o; e.hd = hd;
        return e;
    endfunction

    task automatic step(input logic inc, input logic clr, input logic [4:0] rq,
                        input logic rstn, input exp_t e);
        @(negedge wclk);
        bus.winc     = inc;
        bus.wovf_clr = clr;
        bus.wq2_rptr = rq;
        wrst_n       = rstn;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string f, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h exp=%0h", nm, f, got, exp);
        end
    endtask

    // Monitor: wen sampled mid-cycle (pre-edge), registered outputs just after the edge.
    initial begin : monitor
        logic       wen_smp;
        logic [4:0] prev_p;
        logic [3:0] prev_a;
        exp_t       e;
        prev_p = 5'd0;
        prev_a = 4'd0;
        forever begin
            @(negedge wclk);
            #2;
            wen_smp = bus.wen;
            @(posedge wclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.m[0]) cmp(e.nm, "wen",          32'(wen_smp),          32'(e.wen));
                if (e.m[1]) cmp(e.nm, "waddr",        32'(bus.waddr),        32'(e.waddr));
                if (e.m[2]) cmp(e.nm, "wptr",         32'(bus.wptr),         32'(e.wptr));
                if (e.m[3]) cmp(e.nm, "wfull",        32'(bus.wfull),        32'(e.wfull));
                if (e.m[4]) cmp(e.nm, "walmost_full", 32'(bus.walmost_full), 32'(e.waf));
                if (e.m[5]) cmp(e.nm, "wlevel",       32'(bus.wlevel),       32'(e.wlevel));
                if (e.m[6]) cmp(e.nm, "wovf",         32'(bus.wovf),         32'(e.wovf));
                if (e.hd) begin
                    cmp(e.nm, "wptr_hamming", 32'($countones(prev_p ^ bus.wptr)), 32'd1);
                    if (prev_a == 4'd15 && bus.waddr == 4'd0) wraps++;
                end
                prev_p = bus.wptr;
                prev_a = bus.waddr;
            end
        end
    end

    initial begin : stim
        logic [4:0] rq;
        logic [4:0] lv;
        wclk = 1'b0; wrst_n = 1'b0;
        bus.winc = 1'b0; bus.wovf_clr = 1'b0; bus.wq2_rptr = 5'd0;
        checks = 0; failures = 0; wraps = 0;

        // Reset with a pending write request
        step(1'b1, 1'b0, 5'd0, 1'b0, mk("rst0", NOWEN, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
        step(1'b1, 1'b0, 5'd0, 1'b0, mk("rst1", ALL,   1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));

        // Fill to full
        for (int i = 1; i <= 16; i++)
            step(1'b1, 1'b0, 5'd0, 1'b1, mk("fill", ALL, 1'b1, 4'(i), g(i), (i == 16),
                                            (i >= 12), 5'(i), 1'b0));

        // Overflow, clear, and set-beats-clear
        step(1'b1, 1'b0, 5'd0, 1'b1, mk("ovf",      ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));
        step(1'b0, 1'b1, 5'd0, 1'b1, mk("ovf_clr",  ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0));
        step(1'b1, 1'b1, 5'd0, 1'b1, mk("ovf_wins", ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1));

        // Drain observed through the synchronised read pointer
        step(1'b0, 1'b0, 5'b00110, 1'b1, mk("drain4", ALL, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd12, 1'b1));
        step(1'b0, 1'b0, 5'b00111, 1'b1, mk("drain5", ALL, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b0, 5'd11, 1'b1));
        step(1'b0, 1'b1, 5'b00111, 1'b1, mk("clr2",   ALL, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b0, 5'd11, 1'b0));

        // Wrap: reader returns the pointer from three edges ago
        step(1'b0, 1'b0, 5'd0, 1'b0, mk("rst_w", ALL, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
        for (int k = 1; k <= 40; k++) begin
            rq = (k >= 3) ? g(k - 3) : 5'd0;
            lv = (k < 3) ? 5'(k) : 5'd3;
            step(1'b1, 1'b0, rq, 1'b1, mk("wrap", ALL, 1'b1, 4'(k), g(k), 1'b0, 1'b0, lv, 1'b0, 1'b1));
        end

        // Reset mid-operation at level 9
        step(1'b0, 1'b0, 5'd0, 1'b0, mk("rst_m", ALL, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
        for (int k = 1; k <= 9; k++)
            step(1'b1, 1'b0, 5'd0, 1'b1, mk("pre", ALL, 1'b1, 4'(k), g(k), 1'b0, 1'b0, 5'(k), 1'b0));
        step(1'b1, 1'b0, 5'd0, 1'b0, mk("rst_mid",  ALL, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0));
        step(1'b1, 1'b0, 5'd0, 1'b1, mk("post_rst", ALL, 1'b1, 4'd1, 5'd1, 1'b0, 1'b0, 5'd1, 1'b0));
        step(1'b0, 1'b0, 5'd0, 1'b1, mk("idle",     ALL, 1'b0, 4'd1, 5'd1, 1'b0, 1'b0, 5'd1, 1'b0));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge wclk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
        end
        checks++;
        if (wraps != 2) begin
            failures++;
            $display("FAIL waddr_wraps got=%0d exp=2", wraps);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
